data_memory_unit: RTL and testbench

Parametrised successor to the single-cycle data memory: one word-addressed array shared by a read-only instruction port and a load/store data port. Adds MIPS sub-word access (byte/half/word, signed or unsigned loads, byte-lane stores), alignment and range fault detection, configurable registered read latency with per-request response pulses, and a saturating fault counter. It sits between the CPU datapath (PC fetch, load/store unit) and the memory array.

---
 rtl/data_memory_unit.sv | 206 ++++++++++++++++++++
 tb/tb_data_memory_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// Shared instruction/data word memory with MIPS sub-word loads/stores, fault
// detection, 1- or 2-cycle registered responses and a saturating fault counter.
module data_memory_unit #(
  parameter int          DEPTH        = 1024,
  parameter logic [31:0] OFFSET       = 32'h0,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_req,
  output logic        d_ready,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_fault,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_valid,
  output logic [31:0] i_instr,
  output logic        i_fault,
  output logic [7:0]  fault_count
);
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

  function automatic logic f_in_range(input logic [31:0] rel);
    return {1'b0, rel} < LIMIT;
  endfunction

  function automatic logic f_d_fault(input logic [31:0] rel, input logic [1:0] size);
    logic misaligned;
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = rel[0];
      2'b10:   misaligned = (rel[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    return misaligned || !f_in_range(rel);
  endfunction

  function automatic logic [31:0] f_load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  logic [31:0]   r_mem [DEPTH];
  logic          r_ready;
  logic [7:0]    r_fault_cnt;
  logic          r_s1_dv, r_s1_dflt, r_s1_iv, r_s1_iflt;
  logic [31:0]   r_s1_drdata, r_s1_instr;

  logic [31:0]   w_d_rel, w_i_rel;
  logic [AW-1:0] w_d_idx, w_i_idx;
  logic          w_d_acc, w_i_acc, w_d_flt, w_i_flt, w_d_wr;
  logic [3:0]    w_be;
  logic [31:0]   w_wword, w_d_rdata_nxt, w_i_instr_nxt;
  logic          w_cnt_d, w_cnt_i;
  logic [8:0]    w_cnt_sum;

  // Address decode, fault detection, lane selection and read-data shaping
  always_comb begin
    w_d_rel = d_addr - OFFSET;
    w_i_rel = i_addr - OFFSET;
    w_d_idx = w_d_rel[AW+1:2];
    w_i_idx = w_i_rel[AW+1:2];
    w_d_acc = d_req && r_ready;
    w_i_acc = i_req && r_ready;
    w_d_flt = f_d_fault(w_d_rel, d_size);
    w_i_flt = (w_i_rel[1:0] != 2'b00) || !f_in_range(w_i_rel);
    w_d_wr  = w_d_acc && d_we && !w_d_flt;
    w_be    = 4'b0000;
    w_wword = d_wdata;
    case (d_size)
      2'b00: begin
        w_be    = 4'b0001 << w_d_rel[1:0];
        w_wword = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_d_rel[1] ? 4'b1100 : 4'b0011;
        w_wword = {2{d_wdata[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wword = d_wdata;
      end
      default: begin
        w_be    = 4'b0000;
        w_wword = d_wdata;
      end
    endcase
    if (w_d_acc && !d_we && !w_d_flt) begin
      w_d_rdata_nxt = f_load_ext(r_mem[w_d_idx], d_size, w_d_rel[1:0], d_unsigned);
    end else begin
      w_d_rdata_nxt = 32'h0;
    end
    if (w_i_acc && !w_i_flt) begin
      w_i_instr_nxt = r_mem[w_i_idx];
    end else begin
      w_i_instr_nxt = 32'h0;
    end
  end

  // Byte-lane store; array is deliberately excluded from reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_d_wr && w_be[b]) begin
        r_mem[w_d_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  // Ready flag and first response stage (array read happens at accept)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready     <= 1'b0;
      r_s1_dv     <= 1'b0;
      r_s1_dflt   <= 1'b0;
      r_s1_drdata <= 32'h0;
      r_s1_iv     <= 1'b0;
      r_s1_iflt   <= 1'b0;
      r_s1_instr  <= 32'h0;
    end else begin
      r_ready     <= 1'b1;
      r_s1_dv     <= w_d_acc;
      r_s1_dflt   <= w_d_acc && w_d_flt;
      r_s1_drdata <= w_d_rdata_nxt;
      r_s1_iv     <= w_i_acc;
      r_s1_iflt   <= w_i_acc && w_i_flt;
      r_s1_instr  <= w_i_instr_nxt;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic        r_s2_dv, r_s2_dflt, r_s2_iv, r_s2_iflt;
      logic [31:0] r_s2_drdata, r_s2_instr;

      // Extra output register stage for the two-cycle configuration
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s2_dv     <= 1'b0;
          r_s2_dflt   <= 1'b0;
          r_s2_drdata <= 32'h0;
          r_s2_iv     <= 1'b0;
          r_s2_iflt   <= 1'b0;
          r_s2_instr  <= 32'h0;
        end else begin
          r_s2_dv     <= r_s1_dv;
          r_s2_dflt   <= r_s1_dflt;
          r_s2_drdata <= r_s1_drdata;
          r_s2_iv     <= r_s1_iv;
          r_s2_iflt   <= r_s1_iflt;
          r_s2_instr  <= r_s1_instr;
        end
      end

      assign d_rvalid = r_s2_dv;
      assign d_fault  = r_s2_dflt;
      assign d_rdata  = r_s2_drdata;
      assign i_valid  = r_s2_iv;
      assign i_fault  = r_s2_iflt;
      assign i_instr  = r_s2_instr;
      assign w_cnt_d  = r_s1_dflt;
      assign w_cnt_i  = r_s1_iflt;
    end else begin : g_lat1
      assign d_rvalid = r_s1_dv;
      assign d_fault  = r_s1_dflt;
      assign d_rdata  = r_s1_drdata;
      assign i_valid  = r_s1_iv;
      assign i_fault  = r_s1_iflt;
      assign i_instr  = r_s1_instr;
      assign w_cnt_d  = w_d_acc && w_d_flt;
      assign w_cnt_i  = w_i_acc && w_i_flt;
    end
  endgenerate

  // Counter steps together with the faults that become visible at this edge
  assign w_cnt_sum = {1'b0, r_fault_cnt} + {8'h00, w_cnt_d} + {8'h00, w_cnt_i};

  // Saturating fault counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_cnt <= 8'h00;
    end else begin
      r_fault_cnt <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
    end
  end

  assign d_ready     = r_ready;
  assign fault_count = r_fault_cnt;

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench: two instances (latency 1 and 2) share stimulus; a forked
// monitor pops expected responses and checks data, fault flag and arrival cycle.
module tb_data_memory_unit;
  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          cyc;
  } exp_t;

  logic        clk, rst_n;
  logic        d_req, d_we, d_unsigned, i_req;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, i_addr;

  logic        d_ready_o [2];
  logic        d_rvalid_o [2];
  logic [31:0] d_rdata_o [2];
  logic        d_fault_o [2];
  logic        i_valid_o [2];
  logic [31:0] i_instr_o [2];
  logic        i_fault_o [2];
  logic [7:0]  fault_count_o [2];

  exp_t        qd [2][$];
  exp_t        qi [2][$];
  logic [31:0] mem_m [1024];
  int          n_tests, n_fail, cyc, fc_m;
  logic        ready_m;

  data_memory_unit #(.DEPTH(1024), .OFFSET(32'h0), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .d_req(d_req), .d_ready(d_ready_o[0]), .d_we(d_we),
    .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid_o[0]), .d_rdata(d_rdata_o[0]), .d_fault(d_fault_o[0]),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid_o[0]), .i_instr(i_instr_o[0]),
    .i_fault(i_fault_o[0]), .fault_count(fault_count_o[0]));

  data_memory_unit #(.DEPTH(1024), .OFFSET(32'h0), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .d_req(d_req), .d_ready(d_ready_o[1]), .d_we(d_we),
    .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid_o[1]), .d_rdata(d_rdata_o[1]), .d_fault(d_fault_o[1]),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid_o[1]), .i_instr(i_instr_o[1]),
    .i_fault(i_fault_o[1]), .fault_count(fault_count_o[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic m_dfault(input logic [31:0] a, input logic [1:0] sz);
    return (a >= 32'h1000) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    sh = mem_m[a[11:2]] >> (8 * a[1:0]);
    if (sz == 2'b00) return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    if (sz == 2'b01) return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    return mem_m[a[11:2]];
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) mem_m[a[11:2]][8*a[1:0] +: 8] = wd[7:0];
    else if (sz == 2'b01) mem_m[a[11:2]][16*a[1] +: 16] = wd[15:0];
    else mem_m[a[11:2]] = wd;
  endtask

  // Drive one cycle of requests; on acceptance push the expected responses.
  task automatic req(input logic dv, input logic dwe, input logic [1:0] dsz, input logic duns,
                     input logic [31:0] da, input logic [31:0] dwd, input logic iv, input logic [31:0] ia);
    exp_t e;
    logic flt;
    d_req = dv; d_we = dwe; d_size = dsz; d_unsigned = duns; d_addr = da; d_wdata = dwd;
    i_req = iv; i_addr = ia;
    @(posedge clk); #1;
    d_req = 1'b0; i_req = 1'b0;
    if (ready_m) begin
      if (iv) begin
        flt = (ia >= 32'h1000) || (ia[1:0] != 2'b00);
        e.fault = flt;
        e.data = flt ? 32'h0 : mem_m[ia[11:2]];
        for (int k = 0; k < 2; k++) begin e.cyc = cyc + k; qi[k].push_back(e); end
        if (flt) fc_m = (fc_m < 255) ? fc_m + 1 : 255;
      end
      if (dv) begin
        flt = m_dfault(da, dsz);
        e.fault = flt;
        e.data = (flt || dwe) ? 32'h0 : m_load(da, dsz, duns);
        for (int k = 0; k < 2; k++) begin e.cyc = cyc + k; qd[k].push_back(e); end
        if (!flt && dwe) m_store(da, dsz, dwd);
        if (flt) fc_m = (fc_m < 255) ? fc_m + 1 : 255;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ready_m = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0; i_req = 1'b1; i_addr = 32'h0;
    idle(3);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({d_ready_o[k], d_rvalid_o[k], d_fault_o[k], d_rdata_o[k], i_valid_o[k], i_fault_o[k],
           i_instr_o[k], fault_count_o[k]} !== 77'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: ready=%b rvalid=%b ivalid=%b fc=%0d, all 0 required",
                 k, d_ready_o[k], d_rvalid_o[k], i_valid_o[k], fault_count_o[k]);
      end
    end
    rst_n = 1'b1;
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    ready_m = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (d_ready_o[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL ready_after_reset dut%0d: got %b, expected 1", k, d_ready_o[k]);
      end
    end
    idle(3);
  endtask

  task automatic test_word;
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    idle(3);
  endtask

  task automatic test_byte_half;
    req(1'b1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, 1'b0, 32'h0);
    req(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 32'h10);
    req(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0);
    req(1'b1, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0);
    req(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0);
    req(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0);
    req(1'b1, 1'b1, 2'b01, 1'b0, 32'h16, 32'hAAAA8001, 1'b0, 32'h0);
    req(1'b1, 1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 1'b0, 32'h0);
    req(1'b1, 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b0, 32'h0);
    idle(3);
  endtask

  task automatic test_faults;
    req(1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0);
    req(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    idle(3);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (fault_count_o[k] !== 8'(fc_m) || fc_m != 3) begin
        n_fail++;
        $display("FAIL fault_count_3 dut%0d: got %0d, expected 3", k, fault_count_o[k]);
      end
    end
    req(1'b1, 1'b1, 2'b01, 1'b0, 32'h11, 32'h5555, 1'b0, 32'h0);
    req(1'b1, 1'b1, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    idle(3);
  endtask

  task automatic test_range;
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0, 32'h0);
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0);
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h0BADF00D, 1'b1, 32'hFFC);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFE);
    req(1'b1, 1'b0, 2'b00, 1'b0, 32'hFFF, 32'h0, 1'b1, 32'h1000);
    req(1'b1, 1'b0, 2'b00, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0);
    idle(3);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (fault_count_o[k] !== 8'(fc_m)) begin
        n_fail++;
        $display("FAIL fault_count_range dut%0d: got %0d, expected %0d", k, fault_count_o[k], fc_m);
      end
    end
  endtask

  task automatic test_back_to_back;
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11111111, 1'b1, 32'h10);
    for (int i = 0; i < 6; i++) begin
      req(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0F0F0000 + i, 1'b1, 32'h20);
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h20);
    end
    idle(3);
  endtask

  task automatic test_midstream_reset;
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 1'b1, 32'h10);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b1, 32'hFFE);
    rst_n = 1'b0; ready_m = 1'b0; fc_m = 0;
    for (int k = 0; k < 2; k++) begin qd[k].delete(); qi[k].delete(); end
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({d_ready_o[k], d_rvalid_o[k], d_fault_o[k], d_rdata_o[k], i_valid_o[k], i_fault_o[k],
           i_instr_o[k], fault_count_o[k]} !== 77'h0) begin
        n_fail++;
        $display("FAIL midstream_reset dut%0d: rvalid=%b ivalid=%b rdata=%h fc=%0d, all 0 required",
                 k, d_rvalid_o[k], i_valid_o[k], d_rdata_o[k], fault_count_o[k]);
      end
    end
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 32'h40);
    idle(2);
    rst_n = 1'b1;
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hFFFFFFFF, 1'b0, 32'h0);
    ready_m = 1'b1;
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 32'h40);
    idle(3);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 140; i++) begin
      req(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2);
    end
    idle(3);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (fault_count_o[k] !== 8'hFF || fc_m != 255) begin
        n_fail++;
        $display("FAIL fault_count_saturate dut%0d: got %0d, expected 255", k, fault_count_o[k]);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; fc_m = 0; ready_m = 1'b0; rst_n = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; i_req = 1'b0; i_addr = 32'h0;
    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          while (qd[k].size() > 0 && qd[k][0].cyc < cyc) begin
            void'(qd[k].pop_front());
            n_tests++; n_fail++;
            $display("FAIL d_missing dut%0d: no d_rvalid by cycle %0d", k, cyc);
          end
          while (qi[k].size() > 0 && qi[k][0].cyc < cyc) begin
            void'(qi[k].pop_front());
            n_tests++; n_fail++;
            $display("FAIL i_missing dut%0d: no i_valid by cycle %0d", k, cyc);
          end
          if (d_rvalid_o[k] === 1'b1) begin
            n_tests++;
            if (qd[k].size() == 0) begin
              n_fail++;
              $display("FAIL d_spurious dut%0d: d_rvalid at cycle %0d, none expected", k, cyc);
            end else begin
              exp_t e;
              e = qd[k].pop_front();
              if (d_rdata_o[k] !== e.data || d_fault_o[k] !== e.fault || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL d_resp dut%0d: got data=%h fault=%b cyc=%0d, expected data=%h fault=%b cyc=%0d",
                         k, d_rdata_o[k], d_fault_o[k], cyc, e.data, e.fault, e.cyc);
              end
            end
          end
          if (i_valid_o[k] === 1'b1) begin
            n_tests++;
            if (qi[k].size() == 0) begin
              n_fail++;
              $display("FAIL i_spurious dut%0d: i_valid at cycle %0d, none expected", k, cyc);
            end else begin
              exp_t e;
              e = qi[k].pop_front();
              if (i_instr_o[k] !== e.data || i_fault_o[k] !== e.fault || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL i_resp dut%0d: got instr=%h fault=%b cyc=%0d, expected instr=%h fault=%b cyc=%0d",
                         k, i_instr_o[k], i_fault_o[k], cyc, e.data, e.fault, e.cyc);
              end
            end
          end
        end
      end
    join_none
    test_reset();
    test_word();
    test_byte_half();
    test_faults();
    test_range();
    test_back_to_back();
    test_midstream_reset();
    test_saturation();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
